// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
//   - uart_state_e : transmitter FSM states
//   - DEF_CLK_FREQ / DEF_BAUD : default clock and line rate
//   - cnt_width()  : width of a counter that must hold values 0..n-1 (minimum 1 bit)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned DEF_CLK_FREQ = 32'd120_000_000;
  localparam int unsigned DEF_BAUD     = 32'd115_200;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with first-word-fall-through read.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write strobe and word; accepted when not full or when popping
//   pop        : removes the head word (ignored when empty)
//   rdata      : head word, valid in the same cycle as pop
//   full       : registered, FIFO holds DEPTH words
//   level      : registered word count
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd8,
  parameter int unsigned DEPTH = 32'd16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = cnt_width(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             wr_en_s;
  logic             rd_en_s;

  // Write/read enables, pointer advance (DEPTH is a power of 2 so pointers wrap naturally) and count.
  always_comb begin
    rd_en_s  = pop && (level_q != {LVL_W{1'b0}});
    // A full FIFO can still take a word when the head leaves in the same cycle.
    wr_en_s  = push && (!full_q || rd_en_s);
    wr_ptr_d = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({wr_en_s, rd_en_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d = (level_d == LVL_FULL);
  end

  // Pointer, count and full-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are only ever read behind a valid count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign level = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter (start bit, DATA_BITS LSB first,
// optional parity, STOP_BITS stop bits; line idles high).
// Optional feature: define UART_PARITY_EN to insert a parity bit after the data
// bits (even parity, or odd when PARITY_ODD=1).
//   clk, rst_n : clock, asynchronous active-low reset (aborts any frame)
//   send/data  : push one word per cycle send is high
//   full       : FIFO holds FIFO_DEPTH words
//   overflow   : one-cycle pulse when a send was dropped
//   level      : queued words, excluding the frame in flight
//   busy       : frame in flight or words queued
//   tx         : registered serial output
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
  parameter int unsigned BAUD       = DEF_BAUD,
  parameter int unsigned DATA_BITS  = 32'd8,
  parameter int unsigned STOP_BITS  = 32'd1,
  parameter int unsigned FIFO_DEPTH = 32'd16,
  parameter int unsigned PARITY_ODD = 32'd0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              send,
  input  logic [DATA_BITS-1:0]              data,
  output logic                              full,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              busy,
  output logic                              tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = cnt_width(DATA_BITS);
  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 32'd1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 32'd1);
  localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  uart_state_e           state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  pop_s;
  logic                  bit_end_s;
  logic                  level_nz_s;
  logic                  fifo_full_s;
  logic [DATA_BITS-1:0]  fifo_rdata_s;
  logic [LVL_W-1:0]      fifo_level_s;
`ifdef UART_PARITY_EN
  localparam logic PAR_INV = (PARITY_ODD != 32'd0);
  logic                  parity_q, parity_d;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (send),
    .wdata (data),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .level (fifo_level_s)
  );

  assign bit_end_s  = (baud_q == BAUD_LAST);
  assign level_nz_s = (fifo_level_s != {LVL_W{1'b0}});

  // Frame sequencer: next state, baud/bit counters, shift register and pop request.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_s   = 1'b0;
`ifdef UART_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = BAUD_ZERO;
        bit_d  = BIT_ZERO;
        if (level_nz_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_rdata_s;
`ifdef UART_PARITY_EN
          parity_d = (^fifo_rdata_s) ^ PAR_INV;
`endif
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          baud_d  = BAUD_ZERO;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_d  = BAUD_ZERO;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d = BIT_ZERO;
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) begin
          baud_d  = BAUD_ZERO;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end_s) begin
          baud_d = BAUD_ZERO;
          if (bit_q == STOP_LAST) begin
            bit_d = BIT_ZERO;
            // Pop on the last stop cycle so a queued word starts with no idle gap.
            if (level_nz_s) begin
              pop_s   = 1'b1;
              shift_d = fifo_rdata_s;
`ifdef UART_PARITY_EN
              parity_d = (^fifo_rdata_s) ^ PAR_INV;
`endif
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = BIT_ZERO;
      end
    endcase
  end

  // Output decode from the current state: tx, busy and overflow all appear one edge
  // after the state they describe, which keeps every output a plain flop.
  always_comb begin
    case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
    busy_d     = (state_q != ST_IDLE) || level_nz_s;
    overflow_d = send && fifo_full_s && !pop_s;
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= BAUD_ZERO;
      bit_q      <= BIT_ZERO;
      shift_q    <= {DATA_BITS{1'b0}};
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign full     = fifo_full_s;
  assign level    = fifo_level_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: two instances (1 and 2 stop bits),
// 16 clocks per bit, FIFO depth 4. A frame monitor per instance decodes tx and
// compares each frame against a scoreboard queue filled when words are sent.
module tb_uart_tx_fifo;

  localparam int CPB  = 16;
  localparam int DW   = 8;
  localparam int PODD = 0;
`ifdef UART_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          send0 = 1'b0, send1 = 1'b0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          full0, full1, ovf0, ovf1, busy0, busy1, tx0, tx1;
  logic [2:0]    level0, level1;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            gap_q0[$];
  int            gap_q1[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(DW), .STOP_BITS(1),
                 .FIFO_DEPTH(4), .PARITY_ODD(PODD)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .send(send0), .data(data0), .full(full0),
    .overflow(ovf0), .level(level0), .busy(busy0), .tx(tx0));

  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(DW), .STOP_BITS(2),
                 .FIFO_DEPTH(4), .PARITY_ODD(PODD)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .send(send1), .data(data1), .full(full1),
    .overflow(ovf1), .level(level1), .busy(busy1), .tx(tx1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int id);
    return (id == 0) ? tx0 : tx1;
  endfunction

  function automatic logic get_busy(input int id);
    return (id == 0) ? busy0 : busy1;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Frame decoder: every cycle of every bit must hold the same level.
  task automatic run_mon(input int id);
    int            gap;
    int            nbits;
    logic          v, ok, aborted, has, par;
    logic [DW-1:0] word, exp_w;
    nbits = 1 + DW + PB + ((id == 0) ? 1 : 2);
    gap = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gap = 0;
      end else if (get_tx(id) === 1'b1) begin
        gap++;
      end else begin
        if (id == 0) gap_q0.push_back(gap); else gap_q1.push_back(gap);
        ok = 1'b1; aborted = 1'b0; word = '0; par = 1'b0; v = 1'b0;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int s = 0; s < CPB && !aborted; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (!rst_n) aborted = 1'b1;
            else if (s == 0) v = get_tx(id);
            else if (get_tx(id) !== v) ok = 1'b0;
          end
          if (b == 0) begin
            if (v !== 1'b0) ok = 1'b0;
          end else if (b <= DW) begin
            word[b-1] = v;
          end else if (b == DW + 1 && PB == 1) begin
            par = v;
          end else if (v !== 1'b1) begin
            ok = 1'b0;
          end
        end
        gap = 0;
        if (!aborted) begin
          has = (qsize(id) != 0);
          exp_w = '0;
          if (has) begin
            if (id == 0) exp_w = exp_q0.pop_front(); else exp_w = exp_q1.pop_front();
          end
          check($sformatf("frame%0d_expected", id), has, 1);
          check($sformatf("frame%0d_data", id), word, exp_w);
          check($sformatf("frame%0d_shape", id), ok, 1);
`ifdef UART_PARITY_EN
          check($sformatf("frame%0d_parity", id), par, (^exp_w) ^ PODD[0]);
`endif
        end
      end
    end
  endtask

  initial run_mon(0);
  initial run_mon(1);

  // Single-cycle send strobe, issued from a negative edge.
  task automatic drive_send(input int id, input logic [DW-1:0] d);
    if (id == 0) begin send0 = 1'b1; data0 = d; exp_q0.push_back(d); end
    else         begin send1 = 1'b1; data1 = d; exp_q1.push_back(d); end
    @(negedge clk);
    send0 = 1'b0;
    send1 = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int bound);
    int n;
    n = 0;
    while (n < bound && (get_busy(id) || qsize(id) != 0)) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle%0d_timeout", id), n < bound, 1);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            cyc;
    logic [2:0]    lv_exp [6];
    logic [DW-1:0] rnd;

    // Reset
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx0", tx0, 1);     check("rst_busy0", busy0, 0);
    check("rst_full0", full0, 0); check("rst_ovf0", ovf0, 0);
    check("rst_level0", level0, 0);
    check("rst_tx1", tx1, 1);     check("rst_level1", level1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Test 1: single 8N1 frame, latency and busy duration
    drive_send(0, 8'h2A);
    check("t1_level_k1", level0, 1);
    check("t1_tx_k1", tx0, 1);
    @(negedge clk);
    check("t1_tx_k2", tx0, 1);
    check("t1_level_k2", level0, 0);
    check("t1_busy_k2", busy0, 1);
    @(negedge clk);
    check("t1_tx_start", tx0, 0);
    cyc = 3;
    while (busy0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_busy_fall", cyc - 1, 2 + CPB * (1 + DW + PB + 1));
    wait_idle(0, 50);

    // Test 3: four back-to-back sends, no idle gap between frames
    gap_q0.delete();
    lv_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
    for (int i = 0; i < 4; i++) begin
      send0 = 1'b1;
      data0 = DW'(i + 1);
      exp_q0.push_back(DW'(i + 1));
      @(negedge clk);
      check($sformatf("t3_level_%0d", i), level0, lv_exp[i]);
    end
    send0 = 1'b0;
    wait_idle(0, 1000);
    check("t3_frames", gap_q0.size(), 4);
    for (int i = 1; i < 4 && i < gap_q0.size(); i++)
      check($sformatf("t3_gap_%0d", i), gap_q0[i], 0);

    // Test 4: six sends into a depth-4 FIFO, sixth is dropped
    lv_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int i = 0; i < 6; i++) begin
      send0 = 1'b1;
      data0 = DW'(8'h10 + i);
      if (i < 5) exp_q0.push_back(DW'(8'h10 + i));
      @(negedge clk);
      check($sformatf("t4_level_%0d", i), level0, lv_exp[i]);
      check($sformatf("t4_full_%0d", i), full0, (i >= 4) ? 1 : 0);
      check($sformatf("t4_ovf_%0d", i), ovf0, (i == 5) ? 1 : 0);
    end
    send0 = 1'b0;
    @(negedge clk);
    check("t4_ovf_after", ovf0, 0);
    check("t4_level_after", level0, 4);
    wait_idle(0, 1500);
    check("t4_full_drained", full0, 0);

    // Test 5: reset during data bit 3 aborts the frame
    drive_send(0, 8'h33);
    repeat (73) @(negedge clk);
    check("t5_tx_bit3", tx0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx", tx0, 1);
    check("t5_rst_busy", busy0, 0);
    check("t5_rst_level", level0, 0);
    repeat (5) @(negedge clk);
    exp_q0.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_tx_idle", tx0, 1);
    drive_send(0, 8'h55);
    wait_idle(0, 400);

    // Test 6: two stop bits, two queued words, exactly the stop time between frames
    gap_q1.delete();
    send1 = 1'b1; data1 = 8'hC3; exp_q1.push_back(8'hC3);
    @(negedge clk);
    data1 = 8'h5A; exp_q1.push_back(8'h5A);
    @(negedge clk);
    send1 = 1'b0;
    wait_idle(1, 800);
    check("t6_frames", gap_q1.size(), 2);
    if (gap_q1.size() > 1) check("t6_gap", gap_q1[1], 0);

    // A few random words on the two-stop-bit instance
    for (int i = 0; i < 3; i++) begin
      rnd = DW'($urandom_range(0, 255));
      drive_send(1, rnd);
      wait_idle(1, 500);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
